// File: rtl/lbm_step_scheduler_if.sv
// rtl/lbm_step_scheduler_if.sv - node read/write strobe bundle between step scheduler and memory/solver
interface lbm_step_scheduler_if #(
   parameter int ADDR_W = 10
);
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic              rd_bank;
   logic [9:0]        node_x;
   logic [9:0]        node_y;
   logic              boundary;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic              wr_bank;

   modport master (
      output rd_en, rd_addr, rd_bank, node_x, node_y, boundary,
      output wr_en, wr_addr, wr_bank
   );

   modport slave (
      input rd_en, rd_addr, rd_bank, node_x, node_y, boundary,
      input wr_en, wr_addr, wr_bank
   );
endinterface

// File: rtl/lbm_step_scheduler.sv
// rtl/lbm_step_scheduler.sv - frame-triggered Lattice-Boltzmann timestep sequencer over ping-pong banks
// LBM_FREE_RUN_EN: start steps back-to-back whenever run=1, ignoring vga_done.
module lbm_step_scheduler #(
   parameter int GRID_W = 32,
   parameter int GRID_H = 32,
   parameter int ADDR_W = 10,
   parameter int LAT    = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        run,
   input  logic                        vga_done,
   lbm_step_scheduler_if.master        mem,
   output logic                        busy,
   output logic                        step_done,
   output logic [15:0]                 step_count,
   output logic                        overrun
);
   localparam int                N          = GRID_W * GRID_H;
   localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(N - 1);
   localparam logic [9:0]        LAST_X     = 10'(GRID_W - 1);
   localparam logic [9:0]        LAST_Y     = 10'(GRID_H - 1);
   // every delay stage except the output one; zero means the final write is on the bus now
   localparam logic [LAT-1:0]    EARLY_MASK = {LAT{1'b1}} >> 1;

   typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;

   state_t            state, state_nxt;
   logic              start;
   logic              pending;
   logic              overrun_q;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr_q;
   logic [9:0]        x_q, y_q;
   logic              bank_q;
   logic [15:0]       step_cnt;
   logic [LAT-1:0]    dl_v;
   logic [ADDR_W-1:0] dl_a [LAT];

`ifdef LBM_FREE_RUN_EN
   logic unused_free_run;
   assign unused_free_run = vga_done;
   assign start     = (state == IDLE) && run;
   assign pending   = 1'b0;
   assign overrun_q = 1'b0;
`else
   assign start = (state == IDLE) && run && (vga_done || pending);

   // a trigger consumed on the start edge never lands in pending
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pending   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         overrun_q <= vga_done && pending && !start;
         if (start)
            pending <= 1'b0;
         else if (vga_done)
            pending <= 1'b1;
      end
   end
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = SWEEP;
         SWEEP:   if (rd_addr_q == LAST_ADDR) state_nxt = DRAIN;
         DRAIN:   if ((dl_v & EARLY_MASK) == '0) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      rd_en     = (state == SWEEP);
      busy      = (state != IDLE);
      step_done = (state == DONE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_addr_q <= '0;
         x_q       <= '0;
         y_q       <= '0;
      end else if (state == SWEEP) begin
         if (rd_addr_q == LAST_ADDR) begin
            rd_addr_q <= '0;
            x_q       <= '0;
            y_q       <= '0;
         end else begin
            rd_addr_q <= rd_addr_q + ADDR_W'(1);
            if (x_q == LAST_X) begin
               x_q <= '0;
               y_q <= y_q + 10'd1;
            end else begin
               x_q <= x_q + 10'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bank_q   <= 1'b0;
         step_cnt <= '0;
      end else if (state == DONE) begin
         bank_q   <= ~bank_q;
         step_cnt <= step_cnt + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dl_v <= '0;
         for (int i = 0; i < LAT; i++) dl_a[i] <= '0;
      end else begin
         dl_v[0] <= rd_en;
         dl_a[0] <= rd_addr_q;
         for (int i = 1; i < LAT; i++) begin
            dl_v[i] <= dl_v[i-1];
            dl_a[i] <= dl_a[i-1];
         end
      end
   end

   assign mem.rd_en    = rd_en;
   assign mem.rd_addr  = rd_addr_q;
   assign mem.rd_bank  = bank_q;
   assign mem.node_x   = x_q;
   assign mem.node_y   = y_q;
   assign mem.boundary = rd_en && (x_q == 10'd0 || x_q == LAST_X ||
                                   y_q == 10'd0 || y_q == LAST_Y);
   assign mem.wr_en    = dl_v[LAT-1];
   assign mem.wr_addr  = dl_a[LAT-1];
   assign mem.wr_bank  = ~bank_q;
   assign step_count   = step_cnt;
   assign overrun      = overrun_q;
endmodule
